// File: rtl/fetch_pc_stage_pkg.sv
// Shared fetch definitions: default widths, reset PC and the fetch state encoding
// (kept here so trace/debug code can decode the state register).
package fetch_pc_stage_pkg;

    localparam int BIT_WIDTH      = 32;
    localparam int FETCH_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_stage_mux2.sv
// Two-input selector used to choose the next program counter
// (sequential increment vs redirect target).
module fetch_pc_stage_mux2 #(
    parameter int n = 32
) (
    input  logic         i_sel,
    input  logic [n-1:0] i_in0,
    input  logic [n-1:0] i_in1,
    output logic [n-1:0] o_out
);

    assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch PC stage: owns the PC, runs the req/ack read to instruction memory
// and buffers one fetched word for decode; redirects flush in-flight or buffered fetches.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter int           n        = BIT_WIDTH,
    parameter logic [n-1:0] RESET_PC = n'(FETCH_RESET_PC),
    parameter int           PC_STEP  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [n-1:0] if_pc,
    output logic [n-1:0] if_instr
);

    localparam logic [n-1:0] STEP = n'(PC_STEP);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [n-1:0] r_pc;
    logic [n-1:0] w_pc_nxt;
    logic [n-1:0] r_addr;
    logic [n-1:0] w_addr_nxt;
    logic [n-1:0] r_if_pc;
    logic [n-1:0] w_if_pc_nxt;
    logic [n-1:0] r_if_instr;
    logic [n-1:0] w_if_instr_nxt;
    logic [n-1:0] w_pc_seq;
    logic [n-1:0] w_next_pc;

    // Modulo-2^n increment: the all-ones PC wraps to STEP-1.
    assign w_pc_seq = r_pc + STEP;

    fetch_pc_stage_mux2 #(.n(n)) u_next_pc_mux (
        .i_sel (redirect),
        .i_in0 (w_pc_seq),
        .i_in1 (redirect_pc),
        .o_out (w_next_pc)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
        end
    end

    // NOTE: every next-value defaults to its current register first, so no path infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_addr_nxt     = r_addr;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (redirect) begin
                    w_pc_nxt   = w_next_pc;
                    w_addr_nxt = w_next_pc;
                end else begin
                    w_addr_nxt = r_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_pc_nxt = w_next_pc;
                    if (imem_ack) begin
                        w_addr_nxt = w_next_pc;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end else if (imem_ack) begin
                    w_if_instr_nxt = imem_rdata;
                    w_if_pc_nxt    = r_addr;
                    w_pc_nxt       = w_next_pc;
                    w_state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_next_pc;
                    w_addr_nxt  = w_next_pc;
                    w_state_nxt = REQ;
                end else if (if_ready) begin
                    w_addr_nxt  = r_pc;
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                // The abandoned read must still complete before a new address is presented.
                if (redirect) begin
                    w_pc_nxt = w_next_pc;
                end
                if (imem_ack) begin
                    w_addr_nxt  = redirect ? w_next_pc : r_pc;
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req  = (r_state == REQ) || (r_state == DROP);
    assign imem_addr = r_addr;
    assign if_valid  = (r_state == HOLD);
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage (n=8): a flag-based fetch model checked every cycle,
// an auto-responding instruction memory, and literal checks for each scenario.
module tb_fetch_pc_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       if_valid;
    logic       if_ready = 1'b0;
    logic [7:0] if_pc;
    logic [7:0] if_instr;

    int checks = 0;
    int errors = 0;

    fetch_pc_stage #(.n(8), .RESET_PC(8'h00), .PC_STEP(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks "request outstanding", "its data is stale" and
    // "a word is buffered for decode" as independent facts.
    bit         m_started;
    bit         m_req;
    bit         m_stale;
    bit         m_valid;
    logic [7:0] m_pc;
    logic [7:0] m_addr;
    logic [7:0] m_ifpc;
    logic [7:0] m_ifinstr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_req     <= 1'b0;
            m_stale   <= 1'b0;
            m_valid   <= 1'b0;
            m_pc      <= 8'h00;
            m_addr    <= 8'h00;
            m_ifpc    <= 8'h00;
            m_ifinstr <= 8'h00;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_req     <= 1'b1;
            m_pc      <= redirect ? redirect_pc : m_pc;
            m_addr    <= redirect ? redirect_pc : m_pc;
        end else if (m_req) begin
            if (imem_ack && redirect) begin
                m_pc    <= redirect_pc;
                m_addr  <= redirect_pc;
                m_stale <= 1'b0;
            end else if (imem_ack && m_stale) begin
                m_addr  <= m_pc;
                m_stale <= 1'b0;
            end else if (imem_ack) begin
                m_ifinstr <= imem_rdata;
                m_ifpc    <= m_addr;
                m_pc      <= m_pc + 8'd1;
                m_req     <= 1'b0;
                m_valid   <= 1'b1;
            end else if (redirect) begin
                m_pc    <= redirect_pc;
                m_stale <= 1'b1;
            end
        end else if (m_valid) begin
            if (redirect) begin
                m_valid <= 1'b0;
                m_pc    <= redirect_pc;
                m_addr  <= redirect_pc;
                m_req   <= 1'b1;
            end else if (if_ready) begin
                m_valid <= 1'b0;
                m_addr  <= m_pc;
                m_req   <= 1'b1;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("model imem_req", 32'(imem_req), 32'(m_req));
            check("model imem_addr", 32'(imem_addr), 32'(m_addr));
            check("model if_valid", 32'(if_valid), 32'(m_valid));
            check("model if_pc", 32'(if_pc), 32'(m_ifpc));
            check("model if_instr", 32'(if_instr), 32'(m_ifinstr));
        end
    end

    // Log of words actually handed to decode.
    logic [7:0] acc_pc[$];
    logic [7:0] acc_in[$];
    always @(posedge clk) begin
        if (rst_n && if_valid && if_ready && !redirect) begin
            acc_pc.push_back(if_pc);
            acc_in.push_back(if_instr);
        end
    end

    int mem_lat = 1;
    int req_cnt = 0;
    bit rd_on_ack = 1'b0;

    // One cycle: drive memory response and control inputs just after the falling edge.
    task automatic cyc(input logic rd, input logic [7:0] rpc, input logic rdy);
        @(negedge clk);
        #1;
        if (imem_req) begin
            if (req_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                req_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 8'hEE;
                req_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 8'hEE;
            req_cnt    = 0;
        end
        redirect    = rd | (rd_on_ack & imem_ack);
        redirect_pc = rpc;
        if_ready    = rdy;
    endtask

    task automatic wait_valid(input string name);
        int n_cyc;
        n_cyc = 0;
        while (!if_valid && n_cyc < 20) begin
            cyc(1'b0, 8'h00, 1'b0);
            n_cyc++;
        end
        if (!if_valid) check({name, " timeout"}, 32'(if_valid), 32'd1);
    endtask

    task automatic wait_accepts(input int cnt, input string name);
        int n_cyc;
        n_cyc = 0;
        while (acc_pc.size() < cnt && n_cyc < 60) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_cyc++;
        end
        if (acc_pc.size() < cnt) check({name, " timeout"}, 32'(acc_pc.size()), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cyc;
        // Reset state
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("reset imem_req", 32'(imem_req), 32'd0);
        check("reset imem_addr", 32'(imem_addr), 32'h00);
        check("reset if_valid", 32'(if_valid), 32'd0);
        check("reset if_pc", 32'(if_pc), 32'h00);
        check("reset if_instr", 32'(if_instr), 32'h00);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Sequential fetch, ack one cycle after request, decode always ready
        mem_lat = 1;
        acc_pc.delete();
        acc_in.delete();
        wait_accepts(4, "seq");
        for (int i = 0; i < 4; i++) begin
            if (i < acc_pc.size()) begin
                check($sformatf("seq pc[%0d]", i), 32'(acc_pc[i]), i);
                check($sformatf("seq instr[%0d]", i), 32'(acc_in[i]), 32'(mem_word(8'(i))));
            end
        end

        // Decode stalls five cycles with a word buffered
        wait_valid("stall");
        check("stall if_pc", 32'(if_pc), 32'h04);
        check("stall if_instr", 32'(if_instr), 32'(mem_word(8'h04)));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            check("stall if_valid", 32'(if_valid), 32'd1);
            check("stall if_pc hold", 32'(if_pc), 32'h04);
            check("stall imem_req", 32'(imem_req), 32'd0);
        end

        // Redirect while holding a word
        cyc(1'b1, 8'h40, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("hold-redir if_valid", 32'(if_valid), 32'd0);
        check("hold-redir imem_addr", 32'(imem_addr), 32'h40);
        check("hold-redir imem_req", 32'(imem_req), 32'd1);

        // Redirect with a request outstanding; stale ack arrives three cycles later
        wait_valid("pre-drop");
        mem_lat = 3;
        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b1, 8'h80, 1'b0);
        check("drop req", 32'(imem_req), 32'd1);
        check("drop addr0", 32'(imem_addr), 32'h05);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            check("drop addr held", 32'(imem_addr), 32'h05);
            check("drop req held", 32'(imem_req), 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("drop new addr", 32'(imem_addr), 32'h80);
        check("drop new req", 32'(imem_req), 32'd1);
        check("drop no valid", 32'(if_valid), 32'd0);
        wait_valid("after-drop");
        check("after-drop if_pc", 32'(if_pc), 32'h80);
        check("after-drop if_instr", 32'(if_instr), 32'(mem_word(8'h80)));

        // Redirect in the same cycle as the ack
        mem_lat = 1;
        cyc(1'b0, 8'h00, 1'b1);
        rd_on_ack = 1'b1;
        n_cyc = 0;
        do begin
            cyc(1'b0, 8'h20, 1'b0);
            n_cyc++;
        end while (!imem_ack && n_cyc < 10);
        rd_on_ack = 1'b0;
        check("ack-redir ack seen", 32'(imem_ack), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        check("ack-redir addr", 32'(imem_addr), 32'h20);
        check("ack-redir req", 32'(imem_req), 32'd1);
        check("ack-redir no valid", 32'(if_valid), 32'd0);
        wait_valid("ack-redir fetch");
        check("ack-redir if_pc", 32'(if_pc), 32'h20);

        // PC wrap from all-ones
        cyc(1'b1, 8'hFF, 1'b0);
        acc_pc.delete();
        acc_in.delete();
        wait_accepts(2, "wrap");
        if (acc_pc.size() >= 2) begin
            check("wrap pc0", 32'(acc_pc[0]), 32'hFF);
            check("wrap pc1", 32'(acc_pc[1]), 32'h00);
            check("wrap instr0", 32'(acc_in[0]), 32'(mem_word(8'hFF)));
        end

        // Asynchronous reset in the middle of a request
        mem_lat = 20;
        n_cyc = 0;
        while (!imem_req && n_cyc < 10) begin
            cyc(1'b0, 8'h00, 1'b0);
            n_cyc++;
        end
        check("pre-reset req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst imem_req", 32'(imem_req), 32'd0);
        check("async rst if_valid", 32'(if_valid), 32'd0);
        check("async rst imem_addr", 32'(imem_addr), 32'h00);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        rst_n   = 1'b1;
        mem_lat = 1;
        n_cyc   = 0;
        while (!imem_req && n_cyc < 10) begin
            cyc(1'b0, 8'h00, 1'b0);
            n_cyc++;
        end
        check("post-reset req", 32'(imem_req), 32'd1);
        check("post-reset addr", 32'(imem_addr), 32'h00);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
